// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
//   state_t : controller states (IDLE, RUN, PAUSE)
//   BCD_W   : bits per decimal digit
//   BCD_MAX : largest value a decimal digit can hold
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Front-panel / display bundle of the stopwatch controller.
//   start_stop, clear, lap : synchronised button levels (panel -> controller)
//   bcd                    : displayed count, digit 0 in bits [3:0]
//   running, lap_active    : status flags
//   overflow               : sticky wrap-past-all-9s flag
// master = panel/display side, slave = controller side.
interface stopwatch_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  import stopwatch_pkg::*;

  logic                      start_stop;
  logic                      clear;
  logic                      lap;
  logic [BCD_W*DIGITS-1:0]   bcd;
  logic                      running;
  logic                      lap_active;
  logic                      overflow;

  modport master (
    output start_stop, clear, lap,
    input  bcd, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, clear, lap,
    output bcd, running, lap_active, overflow
  );

endinterface

// File: rtl/bcd_digit.sv
// Single decade (0-9) counter stage.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   en             : advance by one (9 wraps to 0)
//   clr            : synchronous zero, takes priority over en
//   q              : current digit value
//   carry          : en while the digit is at 9 (this step wraps it)
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
    end
  end

  assign carry = en & (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge detection, IDLE/RUN/PAUSE FSM,
// tick prescaler, cascaded BCD digits, lap freeze and overflow flag.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   sw (slave)     : button levels in; bcd/running/lap_active/overflow out
// Parameters: TICK_DIV clock cycles per count tick (>=2), DIGITS digits (>=1).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned DIGITS   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t state, state_next;

  logic start_q, clear_q, lap_q;
  logic ev_start, ev_clear, ev_lap;

  logic [PW-1:0]            presc;
  logic                     tick;
  logic                     clear_now;

  logic [DIGITS-1:0]        en;
  logic [DIGITS-1:0]        carry;
  logic [BCD_W*DIGITS-1:0]  count;
  logic                     wrap;

  logic [BCD_W*DIGITS-1:0]  lap_reg;
  logic                     lap_active;
  logic                     overflow;

  assign ev_start = sw.start_stop & ~start_q;
  assign ev_clear = sw.clear      & ~clear_q;
  assign ev_lap   = sw.lap        & ~lap_q;

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  // Enables are decoded from the registered digits rather than chained
  // through the stage carries, so there is no combinational path from one
  // stage's carry back into the next stage's enable.
  always_comb begin
    logic lower_nines;
    en          = '0;
    lower_nines = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      en[k]       = tick & lower_nines;
      lower_nines = lower_nines & (count[k*BCD_W +: BCD_W] == BCD_MAX);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en[k]),
      .clr     (clear_now),
      .q       (count[k*BCD_W +: BCD_W]),
      .carry   (carry[k])
    );
  end

  // Every stage carries only when the tick hits an all-9s count.
  assign wrap = &carry;

  always_comb begin
    state_next = state;
    clear_now  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev_start) state_next = RUN;
      end
      RUN: begin
        if (ev_start) state_next = PAUSE;
      end
      PAUSE: begin
        if (ev_clear) begin
          state_next = IDLE;
          clear_now  = 1'b1;
        end else if (ev_start) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      lap_q      <= 1'b0;
      presc      <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= sw.start_stop;
      clear_q <= sw.clear;
      lap_q   <= sw.lap;

      if (clear_now) begin
        presc <= '0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + PW'(1);
      end

      if (clear_now) begin
        overflow <= 1'b0;
      end else if (wrap) begin
        overflow <= 1'b1;
      end

      // count still holds its pre-tick value here, which is what a lap captures
      if (clear_now) begin
        lap_active <= 1'b0;
      end else if (ev_lap) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else if (state == RUN) begin
          lap_reg    <= count;
          lap_active <= 1'b1;
        end
      end
    end
  end

  assign sw.bcd        = lap_active ? lap_reg : count;
  assign sw.running    = (state == RUN);
  assign sw.lap_active = lap_active;
  assign sw.overflow   = overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=3, DIGITS=2). An integer-count
// reference model tracks every clock edge; outputs are compared on the
// falling edge each cycle, plus directed scenario checks and a random phase.
module tb_stopwatch_ctrl;

  localparam int unsigned TD  = 3;
  localparam int unsigned DG  = 2;
  localparam int          MOD = 100;

  logic clock;
  logic reset_n;

  stopwatch_ctrl_if #(.DIGITS(DG)) swif ();

  stopwatch_ctrl #(
    .TICK_DIV (TD),
    .DIGITS   (DG)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sw      (swif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int m_count, m_presc, m_lap_val;
  bit m_run, m_pause, m_lap, m_ovf;
  bit p_s, p_c, p_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4*DG-1:0] to_bcd(input int v);
    logic [4*DG-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DG; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_lap_val = 0;
    m_run = 0; m_pause = 0; m_lap = 0; m_ovf = 0;
    p_s = 0; p_c = 0; p_l = 0;
  endtask

  task automatic model_edge();
    bit tick, evs, evc, evl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tick = m_run && (m_presc == TD - 1);
    evs  = swif.start_stop && !p_s;
    evc  = swif.clear && !p_c;
    evl  = swif.lap && !p_l;
    if (evl) begin
      if (m_lap) m_lap = 0;
      else if (m_run) begin
        m_lap_val = m_count;
        m_lap     = 1;
      end
    end
    if (tick) begin
      if (m_count == MOD - 1) begin
        m_count = 0;
        m_ovf   = 1;
      end else begin
        m_count++;
      end
    end
    if (m_run) m_presc = tick ? 0 : m_presc + 1;
    if (m_run) begin
      if (evs) begin m_run = 0; m_pause = 1; end
    end else if (m_pause) begin
      if (evc) begin
        m_pause = 0; m_count = 0; m_presc = 0; m_lap = 0; m_ovf = 0;
      end else if (evs) begin
        m_pause = 0; m_run = 1;
      end
    end else if (evs) begin
      m_run = 1;
    end
    p_s = swif.start_stop; p_c = swif.clear; p_l = swif.lap;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_bcd"}, 32'(swif.bcd), 32'(to_bcd(m_lap ? m_lap_val : m_count)));
    check({tag, "_running"}, 32'(swif.running), 32'(m_run));
    check({tag, "_lap"}, 32'(swif.lap_active), 32'(m_lap));
    check({tag, "_ovf"}, 32'(swif.overflow), 32'(m_ovf));
  endtask

  // called at a falling edge; drives inputs, crosses one rising edge
  task automatic cycle(input bit s, input bit c, input bit l);
    swif.start_stop = s;
    swif.clear      = c;
    swif.lap        = l;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic run_until(input int target, input int want_presc, input int maxc);
    bit hit;
    hit = 0;
    for (int i = 0; i < maxc; i++) begin
      if (m_count == target && (want_presc < 0 || m_presc == want_presc)) begin
        hit = 1;
        break;
      end
      cycle(0, 0, 0);
    end
    if (!hit) hit = (m_count == target && (want_presc < 0 || m_presc == want_presc));
    check("run_until_reached", 32'(hit), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    swif.start_stop = 1'b0;
    swif.clear      = 1'b0;
    swif.lap        = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_bcd", 32'(swif.bcd), 32'h00);
    check("reset_running", 32'(swif.running), 32'd0);
    reset_n = 1'b1;

    // 1: idle, nothing moves
    idle(20);
    check("s1_bcd", 32'(swif.bcd), 32'h00);
    check("s1_ovf", 32'(swif.overflow), 32'd0);

    // 2: start and run 30 cycles
    cycle(1, 0, 0);
    idle(30);
    check("s2_bcd", 32'(swif.bcd), 32'h10);
    check("s2_running", 32'(swif.running), 32'd1);

    // 3: pause, clear, restart, pause at 07, resume, start+clear
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("s3_cleared", 32'(swif.bcd), 32'h00);
    cycle(1, 0, 0);
    run_until(7, 0, 200);
    cycle(1, 0, 0);
    idle(50);
    check("s3_held", 32'(swif.bcd), 32'h07);
    check("s3_paused", 32'(swif.running), 32'd0);
    cycle(1, 0, 0);
    idle(2);
    check("s3_resume", 32'(swif.bcd), 32'h08);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    check("s3_sc_bcd", 32'(swif.bcd), 32'h00);
    check("s3_sc_running", 32'(swif.running), 32'd0);

    // 4: overflow, clear ignored in RUN, clear in PAUSE
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_until(99, -1, 400);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        cycle(0, 0, 0);
        seen = m_ovf;
      end
      check("s4_wrap_seen", 32'(seen), 32'd1);
    end
    check("s4_ovf", 32'(swif.overflow), 32'd1);
    check("s4_bcd", 32'(swif.bcd), 32'h00);
    cycle(0, 1, 0);
    idle(7);
    check("s4_run_clear_ign", 32'(swif.running), 32'd1);
    check("s4_ovf_sticky", 32'(swif.overflow), 32'd1);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("s4_clr_bcd", 32'(swif.bcd), 32'h00);
    check("s4_clr_ovf", 32'(swif.overflow), 32'd0);
    check("s4_clr_running", 32'(swif.running), 32'd0);

    // 5: lap freeze and release
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_until(5, 0, 100);
    cycle(0, 0, 1);
    check("s5_lap_on", 32'(swif.lap_active), 32'd1);
    idle(14);
    check("s5_frozen", 32'(swif.bcd), 32'h05);
    cycle(0, 0, 1);
    check("s5_lap_off", 32'(swif.lap_active), 32'd0);

    // 6: asynchronous reset mid-prescale
    run_until(42, 1, 400);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("s6_async_bcd", 32'(swif.bcd), 32'h00);
    check("s6_async_running", 32'(swif.running), 32'd0);
    check("s6_async_lap", 32'(swif.lap_active), 32'd0);
    check("s6_async_ovf", 32'(swif.overflow), 32'd0);
    @(negedge clock);
    idle(2);
    reset_n = 1'b1;
    idle(10);
    check("s6_post_bcd", 32'(swif.bcd), 32'h00);
    cycle(1, 0, 0);
    idle(10);

    // random button traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
